// File: rtl/im_port_arbiter_if.sv
// im_port_arbiter_if
//   Bundles the fetch, loader and instruction-RAM signals of im_port_arbiter.
//   slave  : the arbiter's view (requests and RAM read data in; grants,
//            responses and RAM controls out).
//   master : the environment's view (fetch unit, loader and RAM model).
//   Fetch  : f_req, f_pc -> f_gnt, f_valid, f_instr, f_fault
//   Loader : l_req, l_addr, l_wdata -> l_gnt, l_ack, l_err
//   RAM    : mem_en, mem_we, mem_addr[AW], mem_wdata <- mem_rdata
interface im_port_arbiter_if #(
  parameter int AW = 12
);
  logic          f_req;
  logic [31:0]   f_pc;
  logic          f_gnt;
  logic          f_valid;
  logic [31:0]   f_instr;
  logic          f_fault;
  logic          l_req;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          l_gnt;
  logic          l_ack;
  logic          l_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  f_req, f_pc, l_req, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_valid, f_instr, f_fault, l_gnt, l_ack, l_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_pc, l_req, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_valid, f_instr, f_fault, l_gnt, l_ack, l_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/im_port_arbiter.sv
// im_port_arbiter
//   Shares one single-port synchronous instruction RAM between the CPU fetch
//   port and a code-loader port. Byte addresses are translated to word
//   indices relative to BASE_ADDR and checked for range and alignment; a
//   faulting request is answered without touching the RAM. The loader has
//   priority, but after MAX_BURST consecutive loader grants with a fetch
//   waiting, the fetch is granted once.
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : im_port_arbiter_if.slave (fetch, loader and RAM signals)
module im_port_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          AW        = 12,
  parameter int          MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  im_port_arbiter_if.slave bus
);

  localparam int            BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);
  // Window size in bytes; one extra bit so 4*2**AW never overflows.
  localparam logic [32:0]   SPAN      = 33'd4 << AW;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_OK  = 3'd1,
    S_RD_FLT = 3'd2,
    S_WR_OK  = 3'd3,
    S_WR_FLT = 3'd4
  } resp_t;

  // Word aligned and inside the window; an address below BASE_ADDR wraps
  // to a huge offset and is rejected by the same compare.
  function automatic logic addr_ok(input logic [1:0] lsb, input logic [31:0] off);
    return (lsb == 2'b00) && ({1'b0, off} < SPAN);
  endfunction

  logic [31:0]   w_f_off;
  logic [31:0]   w_l_off;
  logic          w_f_ok;
  logic          w_l_ok;
  logic          w_f_gnt;
  logic          w_l_gnt;
  logic [BW-1:0] w_bcnt_nxt;
  resp_t         w_state_nxt;
  logic          w_f_valid_nxt;
  logic          w_f_fault_nxt;
  logic          w_l_ack_nxt;
  logic          w_l_err_nxt;

  resp_t         r_state;
  logic [BW-1:0] r_bcnt;
  logic          r_f_valid;
  logic          r_f_fault;
  logic          r_l_ack;
  logic          r_l_err;

  assign w_f_off = bus.f_pc - BASE_ADDR;
  assign w_l_off = bus.l_addr - BASE_ADDR;
  assign w_f_ok  = addr_ok(bus.f_pc[1:0], w_f_off);
  assign w_l_ok  = addr_ok(bus.l_addr[1:0], w_l_off);

  // Arbitration, RAM drive and burst-counter update for the current cycle.
  always_comb begin
    w_l_gnt       = 1'b0;
    w_f_gnt       = 1'b0;
    w_bcnt_nxt    = r_bcnt;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = w_f_off[AW+1:2];
    bus.mem_wdata = bus.l_wdata;

    // Loader wins unless the waiting fetch has already lost MAX_BURST times.
    if (bus.l_req && !(bus.f_req && (r_bcnt == BURST_LIM))) begin
      w_l_gnt = 1'b1;
    end else begin
      w_f_gnt = bus.f_req;
    end

    if (w_l_gnt) begin
      bus.mem_en   = w_l_ok;
      bus.mem_we   = w_l_ok;
      bus.mem_addr = w_l_off[AW+1:2];
    end else if (w_f_gnt) begin
      bus.mem_en   = w_f_ok;
    end else begin
      bus.mem_en   = 1'b0;
    end

    if (!bus.f_req || w_f_gnt) begin
      w_bcnt_nxt = {BW{1'b0}};
    end else if (w_l_gnt && (r_bcnt < BURST_LIM)) begin
      w_bcnt_nxt = r_bcnt + {{(BW-1){1'b0}}, 1'b1};
    end else begin
      w_bcnt_nxt = r_bcnt;
    end
  end

  // Next response state and the response flags it implies.
  always_comb begin
    w_state_nxt   = S_IDLE;
    w_f_valid_nxt = 1'b0;
    w_f_fault_nxt = 1'b0;
    w_l_ack_nxt   = 1'b0;
    w_l_err_nxt   = 1'b0;

    if (w_l_gnt) begin
      w_state_nxt = w_l_ok ? S_WR_OK : S_WR_FLT;
    end else if (w_f_gnt) begin
      w_state_nxt = w_f_ok ? S_RD_OK : S_RD_FLT;
    end else begin
      w_state_nxt = S_IDLE;
    end

    case (w_state_nxt)
      S_RD_OK:  w_f_valid_nxt = 1'b1;
      S_RD_FLT: begin
        w_f_valid_nxt = 1'b1;
        w_f_fault_nxt = 1'b1;
      end
      S_WR_OK:  w_l_ack_nxt = 1'b1;
      S_WR_FLT: begin
        w_l_ack_nxt = 1'b1;
        w_l_err_nxt = 1'b1;
      end
      default: begin
        w_f_valid_nxt = 1'b0;
        w_l_ack_nxt   = 1'b0;
      end
    endcase
  end

  // State, burst counter and registered response flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_bcnt    <= {BW{1'b0}};
      r_f_valid <= 1'b0;
      r_f_fault <= 1'b0;
      r_l_ack   <= 1'b0;
      r_l_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_f_valid <= w_f_valid_nxt;
      r_f_fault <= w_f_fault_nxt;
      r_l_ack   <= w_l_ack_nxt;
      r_l_err   <= w_l_err_nxt;
    end
  end

  assign bus.f_gnt   = w_f_gnt;
  assign bus.l_gnt   = w_l_gnt;
  assign bus.f_valid = r_f_valid;
  assign bus.f_fault = r_f_fault;
  assign bus.l_ack   = r_l_ack;
  assign bus.l_err   = r_l_err;
  // RAM read data arrives the cycle after the grant, so it is passed through
  // rather than registered again; faults and idle cycles read as zero.
  assign bus.f_instr = (r_state == S_RD_OK) ? bus.mem_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_im_port_arbiter.sv
// tb_im_port_arbiter
//   Directed stimulus with a queue-based scoreboard: each issued request
//   pushes its expected response, and a monitor pops and compares whenever
//   f_valid or l_ack is seen. The RAM is modelled here; a shadow copy holds
//   the contents the bench expects.
module tb_im_port_arbiter;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
    int          cyc;
  } f_exp_t;

  typedef struct {
    logic err;
    int   cyc;
  } l_exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic preload = 1'b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  f_exp_t fq[$];
  l_exp_t lq[$];

  logic [31:0] ram    [DEPTH];
  logic [31:0] shadow [DEPTH];

  logic [31:0] la;
  logic [31:0] ld;
  int          widx;

  always #5 clk = ~clk;

  im_port_arbiter_if #(.AW(AW)) bus ();

  im_port_arbiter #(
    .BASE_ADDR (32'h0000_3000),
    .AW        (AW),
    .MAX_BURST (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(i);
    if (i == 0) w = 32'h2408_0001;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port RAM model.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  // Monitor: compare each presented response with the scoreboard head.
  always @(negedge clk) begin
    if (bus.f_valid === 1'b1) begin
      if (fq.size() == 0) begin
        chk("f_unexpected_valid", 32'd1, 32'd0);
      end else begin
        f_exp_t e;
        e = fq.pop_front();
        chk("f_instr", bus.f_instr, e.instr);
        chk("f_fault", {31'd0, bus.f_fault}, {31'd0, e.fault});
        chk("f_latency", 32'(cyc), 32'(e.cyc + 1));
      end
    end
    if (bus.l_ack === 1'b1) begin
      if (lq.size() == 0) begin
        chk("l_unexpected_ack", 32'd1, 32'd0);
      end else begin
        l_exp_t e;
        e = lq.pop_front();
        chk("l_err", {31'd0, bus.l_err}, {31'd0, e.err});
        chk("l_latency", 32'(cyc), 32'(e.cyc + 1));
      end
    end
    if (fq.size() > 0 && (fq[0].cyc + 1 < cyc)) begin
      chk("f_missing_response", 32'(fq[0].cyc + 1), 32'(cyc));
      void'(fq.pop_front());
    end
    if (lq.size() > 0 && (lq[0].cyc + 1 < cyc)) begin
      chk("l_missing_response", 32'(lq[0].cyc + 1), 32'(cyc));
      void'(lq.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] pc, input logic flt,
                          input logic [31:0] instr, input logic [AW-1:0] idx);
    bus.f_req = 1'b1;
    bus.f_pc  = pc;
    bus.l_req = 1'b0;
    @(negedge clk);
    chk("f_gnt", {31'd0, bus.f_gnt}, 32'd1);
    chk("f_l_gnt_low", {31'd0, bus.l_gnt}, 32'd0);
    chk("f_mem_en", {31'd0, bus.mem_en}, {31'd0, ~flt});
    chk("f_mem_we", {31'd0, bus.mem_we}, 32'd0);
    if (!flt) chk("f_mem_addr", 32'(bus.mem_addr), 32'(idx));
    fq.push_back('{instr, flt, cyc});
    step();
    bus.f_req = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic err, input logic [AW-1:0] idx);
    bus.l_req   = 1'b1;
    bus.l_addr  = addr;
    bus.l_wdata = data;
    bus.f_req   = 1'b0;
    @(negedge clk);
    chk("l_gnt", {31'd0, bus.l_gnt}, 32'd1);
    chk("l_f_gnt_low", {31'd0, bus.f_gnt}, 32'd0);
    chk("l_mem_en", {31'd0, bus.mem_en}, {31'd0, ~err});
    chk("l_mem_we", {31'd0, bus.mem_we}, {31'd0, ~err});
    if (!err) begin
      chk("l_mem_addr", 32'(bus.mem_addr), 32'(idx));
      chk("l_mem_wdata", bus.mem_wdata, data);
      shadow[idx] = data;
    end
    lq.push_back('{err, cyc});
    step();
    bus.l_req = 1'b0;
  endtask

  // Both ports request for n cycles; every fifth grant must go to fetch.
  task automatic burst(input int n);
    int fidx;
    fidx = 0;
    bus.f_req   = 1'b1;
    bus.f_pc    = 32'h0000_3000;
    bus.l_req   = 1'b1;
    bus.l_addr  = la;
    bus.l_wdata = ld;
    for (int k = 0; k < n; k++) begin
      logic exp_f;
      @(negedge clk);
      exp_f = ((k % 5) == 4);
      chk($sformatf("burst_f_gnt%0d", k), {31'd0, bus.f_gnt}, {31'd0, exp_f});
      chk($sformatf("burst_l_gnt%0d", k), {31'd0, bus.l_gnt}, {31'd0, ~exp_f});
      if (exp_f) begin
        fq.push_back('{shadow[fidx], 1'b0, cyc});
        fidx++;
      end else begin
        lq.push_back('{1'b0, cyc});
        shadow[widx] = ld;
        widx++;
        la = la + 32'd4;
        ld = ld + 32'd1;
      end
      step();
      bus.f_pc    = 32'h0000_3000 + 32'(4 * fidx);
      bus.l_addr  = la;
      bus.l_wdata = ld;
    end
    bus.f_req = 1'b0;
    bus.l_req = 1'b0;
  endtask

  initial begin
    bus.f_req     = 1'b0;
    bus.f_pc      = 32'h0000_0000;
    bus.l_req     = 1'b0;
    bus.l_addr    = 32'h0000_0000;
    bus.l_wdata   = 32'h0000_0000;
    la   = 32'h0000_3100;
    ld   = 32'h1000_0000;
    widx = 32'h40;
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);

    // Reset state.
    @(negedge clk);
    chk("rst_f_valid", {31'd0, bus.f_valid}, 32'd0);
    chk("rst_f_fault", {31'd0, bus.f_fault}, 32'd0);
    chk("rst_l_ack",   {31'd0, bus.l_ack},   32'd0);
    chk("rst_l_err",   {31'd0, bus.l_err},   32'd0);
    chk("rst_f_instr", bus.f_instr, 32'd0);
    step();
    reset   = 1'b1;
    preload = 1'b0;
    step();

    // 1: basic fetch of word 0.
    do_fetch(32'h0000_3000, 1'b0, shadow[0], 12'h000);
    // 2: loader write, then fetch it back.
    do_write(32'h0000_4180, 32'hDEAD_BEEF, 1'b0, 12'h460);
    do_fetch(32'h0000_4180, 1'b0, 32'hDEAD_BEEF, 12'h460);
    step();
    // 3: contention for 10 cycles.
    burst(10);
    step();
    // 4: faulting fetches (underflow, past the end, misaligned).
    do_fetch(32'h0000_2FFC, 1'b1, 32'h0000_0000, 12'h000);
    do_fetch(32'h0000_7000, 1'b1, 32'h0000_0000, 12'h000);
    do_fetch(32'h0000_3002, 1'b1, 32'h0000_0000, 12'h000);
    // 5: faulting write, then read back every word.
    do_write(32'h0000_8000, 32'h5555_AAAA, 1'b1, 12'h000);
    bus.f_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.f_pc = 32'h0000_3000 + 32'(4 * i);
      @(negedge clk);
      chk("sweep_f_gnt", {31'd0, bus.f_gnt}, 32'd1);
      fq.push_back('{shadow[i], 1'b0, cyc});
      step();
    end
    bus.f_req = 1'b0;
    step();

    // 6: reset right behind a fetch grant discards its response.
    bus.f_req = 1'b1;
    bus.f_pc  = 32'h0000_3000;
    @(negedge clk);
    chk("rst6_f_gnt", {31'd0, bus.f_gnt}, 32'd1);
    reset     = 1'b0;
    bus.f_req = 1'b0;
    step();
    @(negedge clk);
    chk("rst6_f_valid", {31'd0, bus.f_valid}, 32'd0);
    chk("rst6_l_ack",   {31'd0, bus.l_ack},   32'd0);
    step();
    reset = 1'b1;
    step();
    burst(5);
    do_fetch(32'h0000_3000, 1'b0, 32'h2408_0001, 12'h000);

    repeat (3) step();
    chk("fq_drained", 32'(fq.size()), 32'd0);
    chk("lq_drained", 32'(lq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
